// File: rtl/md5_digest_matcher.sv
// Watches the in-order MD5 digest stream for the first hash with enough leading zero hex characters.
// On a hit it stops block issue, waits for in-flight digests to drain, then holds the winning suffix.
`timescale 1ns/1ps
module md5_digest_matcher #(
  parameter int DIGEST_WIDTH  = 128,
  parameter int RESULT_WIDTH  = 32,
  parameter int ZERO_NIBBLES  = 5,
  parameter int FIRST_INDEX   = 1,
  parameter int MAX_IN_FLIGHT = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    block_issued,
  input  logic                    digest_valid,
  input  logic [DIGEST_WIDTH-1:0] digest_data,
  output logic                    stop,
  output logic                    result_valid,
  output logic [RESULT_WIDTH-1:0] result_data,
  output logic                    protocol_error
);

  localparam int IFW        = $clog2(MAX_IN_FLIGHT + 1);
  localparam int MATCH_BITS = 4 * ZERO_NIBBLES;
  localparam logic [IFW-1:0]          MAX_COUNT   = IFW'(MAX_IN_FLIGHT);
  localparam logic [RESULT_WIDTH-1:0] FIRST_VALUE = RESULT_WIDTH'(FIRST_INDEX);

  typedef enum logic [1:0] {SEARCH, DRAIN, DONE} state_t;

  state_t                  state;
  logic [IFW-1:0]          in_flight;
  logic [RESULT_WIDTH-1:0] digest_index;
  logic [RESULT_WIDTH-1:0] hit_index_q;
  logic                    hit_q;

  logic digest_match;
  logic orphan_digest;
  logic digest_accepted;
  logic compare_en;
  logic index_at_max;
  logic error_now;

  // Shifting the top MATCH_BITS down to bit 0 leaves zero only when all those nibbles are zero.
  assign digest_match    = ((digest_data >> (DIGEST_WIDTH - MATCH_BITS)) == '0);
  assign orphan_digest   = digest_valid && (in_flight == '0) && !block_issued;
  assign digest_accepted = digest_valid && !orphan_digest;
  assign compare_en      = digest_accepted && (state == SEARCH);
  assign index_at_max    = (digest_index == '1);

  assign error_now = orphan_digest
                  || (block_issued && (in_flight == MAX_COUNT))
                  || (block_issued && (state == DONE))
                  || (compare_en && index_at_max);

  // Outstanding block count; frozen once the result is final.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_flight <= '0;
    end else if (state != DONE) begin
      if (block_issued && !digest_accepted) begin
        if (in_flight != MAX_COUNT) begin
          in_flight <= in_flight + 1'b1;
        end
      end else if (digest_accepted && !block_issued) begin
        in_flight <= in_flight - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q        <= 1'b0;
      hit_index_q  <= '0;
      digest_index <= FIRST_VALUE;
    end else begin
      hit_q <= compare_en && digest_match;
      if (compare_en) begin
        hit_index_q <= digest_index;
        if (!index_at_max) begin
          digest_index <= digest_index + 1'b1;
        end
      end
    end
  end

  // A hit seen in DRAIN comes from a later digest and is deliberately ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SEARCH;
      stop         <= 1'b0;
      result_valid <= 1'b0;
      result_data  <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (hit_q) begin
            state       <= DRAIN;
            stop        <= 1'b1;
            result_data <= hit_index_q;
          end
        end
        DRAIN: begin
          if (in_flight == '0) begin
            state        <= DONE;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if (error_now) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md5_digest_matcher.sv
// Directed bench for md5_digest_matcher: a cycle-timestamp model checked every cycle plus literal checks.
`timescale 1ns/1ps
module tb_md5_digest_matcher;

  localparam int DW  = 128;
  localparam int RW  = 32;
  localparam int ZN  = 5;
  localparam int FI  = 1;
  localparam int MIF = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          block_issued = 1'b0;
  logic          digest_valid = 1'b0;
  logic [DW-1:0] digest_data = '0;
  logic          stop;
  logic          result_valid;
  logic [RW-1:0] result_data;
  logic          protocol_error;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  md5_digest_matcher #(
    .DIGEST_WIDTH(DW), .RESULT_WIDTH(RW), .ZERO_NIBBLES(ZN),
    .FIRST_INDEX(FI), .MAX_IN_FLIGHT(MIF)
  ) dut (
    .clk(clk), .reset(reset), .block_issued(block_issued),
    .digest_valid(digest_valid), .digest_data(digest_data),
    .stop(stop), .result_valid(result_valid), .result_data(result_data),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  // Model: cycle numbers of the first matching digest and of the final result, plus plain counters.
  int      cyc = 0;
  int      m_in_flight;
  longint  m_next_index;
  longint  m_result;
  int      m_match_cyc;
  int      m_done_cyc;
  bit      m_err;
  bit      ph_done, ph_drain, ph_search, acc, is_match;

  function automatic int leading_zero_nibbles(input logic [DW-1:0] d);
    int n = 0;
    for (int i = DW / 4 - 1; i >= 0; i--) begin
      if (d[i*4 +: 4] != 4'h0) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] dig(input logic [31:0] top);
    return {top, 96'h0123_4567_89AB_CDEF_0123_4567};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_in_flight  = 0;
      m_next_index = FI;
      m_result     = 0;
      m_match_cyc  = -1;
      m_done_cyc   = -1;
      m_err        = 1'b0;
    end else begin
      ph_done   = (m_done_cyc >= 0) && (cyc >= m_done_cyc);
      ph_search = !((m_match_cyc >= 0) && (cyc >= m_match_cyc + 2));
      ph_drain  = !ph_search && !ph_done;
      is_match  = leading_zero_nibbles(digest_data) >= ZN;
      acc       = digest_valid && ((m_in_flight > 0) || block_issued);
      if (digest_valid && !acc) m_err = 1'b1;
      if (block_issued && (m_in_flight == MIF)) m_err = 1'b1;
      if (block_issued && ph_done) m_err = 1'b1;
      if (ph_search && acc) begin
        if (is_match && (m_match_cyc < 0)) begin
          m_match_cyc = cyc;
          m_result    = m_next_index;
        end
        if (m_next_index == 64'hFFFF_FFFF) m_err = 1'b1;
        else m_next_index++;
      end
      if (ph_drain && (m_in_flight == 0)) m_done_cyc = cyc + 1;
      if (!ph_done) begin
        m_in_flight = m_in_flight + int'(block_issued) - int'(acc);
        if (m_in_flight > MIF) m_in_flight = MIF;
      end
    end
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      bit exp_stop;
      exp_stop = (m_match_cyc >= 0) && (cyc >= m_match_cyc + 2);
      checkOutput("stop", stop, exp_stop);
      checkOutput("result_data", result_data, exp_stop ? m_result[RW-1:0] : '0);
      checkOutput("result_valid", result_valid, (m_done_cyc >= 0) && (cyc >= m_done_cyc));
      checkOutput("protocol_error", protocol_error, m_err);
    end
  end

  task automatic applyStimulus(input logic bi, input logic dv, input logic [DW-1:0] d);
    block_issued = bi;
    digest_valid = dv;
    digest_data  = d;
    @(posedge clk);
    #1;
    block_issued = 1'b0;
    digest_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, '0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checking = 1'b1;
    checkOutput("reset_stop", stop, 0);
    checkOutput("reset_result_valid", result_valid, 0);
    checkOutput("reset_result_data", result_data, 0);
    checkOutput("reset_protocol_error", protocol_error, 0);

    // Basic match: third digest has five leading zero nibbles
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, dig(32'h0000_1F00));
    applyStimulus(1'b0, 1'b1, dig(32'h0000_1000));
    applyStimulus(1'b0, 1'b1, dig(32'h0000_00AB));
    checkOutput("basic_stop_t1", stop, 0);
    idle_cycles(1);
    checkOutput("basic_stop_t2", stop, 1);
    checkOutput("basic_result_data", result_data, 3);
    checkOutput("basic_valid_t2", result_valid, 0);
    checkOutput("model_basic_result", m_result, 3);
    idle_cycles(1);
    checkOutput("basic_valid_t3", result_valid, 1);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("issue_in_done_error", protocol_error, 1);

    // Drain: digest 4 matches, later matches at 6 and 8 are discarded
    pulse_reset();
    repeat (10) applyStimulus(1'b1, 1'b0, '0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, (i == 4 || i == 6 || i == 8) ? dig(32'h0000_0ABC) : dig(32'h1234_5678));
      checkOutput("drain_valid_low", result_valid, 0);
    end
    idle_cycles(1);
    checkOutput("drain_valid_high", result_valid, 1);
    checkOutput("drain_result_data", result_data, 4);
    checkOutput("drain_no_error", protocol_error, 0);

    // Boundary nibbles
    pulse_reset();
    repeat (2) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, dig(32'h0000_8F00));
    applyStimulus(1'b0, 1'b1, dig(32'h0000_0F00));
    idle_cycles(1);
    checkOutput("nibble_0000F_result", result_data, 2);
    idle_cycles(1);
    checkOutput("nibble_valid_t3", result_valid, 1);
    pulse_reset();
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
    idle_cycles(1);
    checkOutput("all_zero_result", result_data, 1);
    pulse_reset();
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, dig(32'h0000_0800));
    idle_cycles(1);
    checkOutput("sixth_nibble_set_result", result_data, 1);
    checkOutput("sixth_nibble_set_stop", stop, 1);

    // Simultaneous issue and digest for 100 cycles
    pulse_reset();
    repeat (100) applyStimulus(1'b1, 1'b1, dig(32'hFFFF_FFFF));
    checkOutput("simul_no_error", protocol_error, 0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, dig(32'h0000_0000));
    idle_cycles(1);
    checkOutput("simul_index_101", result_data, 101);
    idle_cycles(1);
    checkOutput("simul_valid", result_valid, 1);

    // Orphan digest: error, index unchanged
    pulse_reset();
    applyStimulus(1'b0, 1'b1, dig(32'h0000_0000));
    checkOutput("orphan_error", protocol_error, 1);
    checkOutput("orphan_no_stop", stop, 0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, dig(32'h0000_0000));
    idle_cycles(1);
    checkOutput("orphan_index_kept", result_data, 1);
    checkOutput("orphan_error_sticky", protocol_error, 1);

    // Overflow of the in-flight count
    pulse_reset();
    repeat (64) applyStimulus(1'b1, 1'b0, '0);
    checkOutput("issue64_no_error", protocol_error, 0);
    applyStimulus(1'b1, 1'b0, '0);
    checkOutput("issue65_error", protocol_error, 1);

    // Reset in the middle of DRAIN
    pulse_reset();
    applyStimulus(1'b0, 1'b1, dig(32'hFFFF_FFFF));
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, dig(32'h0000_0000));
    idle_cycles(1);
    checkOutput("middrain_stop", stop, 1);
    checkOutput("middrain_error", protocol_error, 1);
    pulse_reset();
    checkOutput("after_reset_stop", stop, 0);
    checkOutput("after_reset_valid", result_valid, 0);
    checkOutput("after_reset_data", result_data, 0);
    checkOutput("after_reset_error", protocol_error, 0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, dig(32'h0000_0000));
    idle_cycles(1);
    checkOutput("restart_index", result_data, FI);
    idle_cycles(2);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
